// File: rtl/pl_pkg.sv
// Shared definitions for the IF/ID skid-buffered pipeline register.
// Holds the state encoding and the default bubble instruction.
package pl_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/pl_slot.sv
// One pipeline storage slot: valid flag plus payload and instruction.
// Clear wins over load and returns the slot to its bubble contents.
module pl_slot
    import pl_pkg::*;
#(
    parameter int unsigned          DATA_W    = 97,
    parameter int unsigned          INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               valid_o,
    output logic [DATA_W-1:0]  data_o,
    output logic [INSTR_W-1:0] instr_o
);

    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  data_q,  data_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    // Next-state selection: clear, load, or hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        instr_d = instr_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = '0;
            instr_d = NOP_INSTR;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            instr_d = instr_i;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot registers; an empty slot always carries bubble contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_id_skid_regs.sv
// IF->ID pipeline register with a one-entry skid slot so up_ready_o is
// purely registered; also tracks occupancy and upstream stall cycles.
module if_id_skid_regs
    import pl_pkg::*;
#(
    parameter int unsigned          DATA_W    = 97,
    parameter int unsigned          INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
    parameter int unsigned          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up_valid_i,
    output logic               up_ready_o,
    input  logic [DATA_W-1:0]  up_data_i,
    input  logic [INSTR_W-1:0] up_instr_i,
    output logic               dn_valid_o,
    input  logic               dn_ready_i,
    output logic [DATA_W-1:0]  dn_data_o,
    output logic [INSTR_W-1:0] dn_instr_o,
    input  logic               flush_i,
    output logic [1:0]         occupancy_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic               main_valid_s, skid_valid_s;
    logic [DATA_W-1:0]  main_data_s,  skid_data_s;
    logic [INSTR_W-1:0] main_instr_s, skid_instr_s;

    logic               main_load_s, main_clear_s, main_from_skid_s;
    logic               skid_load_s, skid_clear_s;
    logic [DATA_W-1:0]  main_data_in_s;
    logic [INSTR_W-1:0] main_instr_in_s;
    logic               up_fire_s, dn_fire_s;

    assign up_ready_o = ~skid_valid_s;
    assign dn_valid_o = main_valid_s;
    assign dn_data_o  = main_data_s;
    assign dn_instr_o = main_instr_s;
    assign occupancy_o = state_q;
    assign stall_cnt_o = stall_q;

    assign up_fire_s = up_valid_i & up_ready_o;
    assign dn_fire_s = main_valid_s & dn_ready_i;

    assign main_data_in_s  = main_from_skid_s ? skid_data_s  : up_data_i;
    assign main_instr_in_s = main_from_skid_s ? skid_instr_s : up_instr_i;

    // Next-state and slot control; flush overrides every handshake.
    always_comb begin
        state_d          = state_q;
        main_load_s      = 1'b0;
        main_clear_s     = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        skid_clear_s     = 1'b0;
        if (flush_i) begin
            state_d      = ST_EMPTY;
            main_clear_s = 1'b1;
            skid_clear_s = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (up_fire_s) begin
                        main_load_s = 1'b1;
                        state_d     = ST_FULL;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (up_fire_s && dn_fire_s) begin
                        main_load_s = 1'b1;
                    end else if (up_fire_s) begin
                        skid_load_s = 1'b1;
                        state_d     = ST_SKID;
                    end else if (dn_fire_s) begin
                        main_clear_s = 1'b1;
                        state_d      = ST_EMPTY;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_SKID: begin
                    // up_ready_o is low here, so only a downstream fire moves data.
                    if (dn_fire_s) begin
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        skid_clear_s     = 1'b1;
                        state_d          = ST_FULL;
                    end else begin
                        state_d = ST_SKID;
                    end
                end
                default: begin
                    state_d      = ST_EMPTY;
                    main_clear_s = 1'b1;
                    skid_clear_s = 1'b1;
                end
            endcase
        end
    end

    // Saturating count of cycles where upstream offers a beat we refuse.
    always_comb begin
        stall_d = stall_q;
        if (up_valid_i && !up_ready_o && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // State and stall counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    pl_slot #(
        .DATA_W    (DATA_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_load_s),
        .clear_i (main_clear_s),
        .data_i  (main_data_in_s),
        .instr_i (main_instr_in_s),
        .valid_o (main_valid_s),
        .data_o  (main_data_s),
        .instr_o (main_instr_s)
    );

    pl_slot #(
        .DATA_W    (DATA_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load_s),
        .clear_i (skid_clear_s),
        .data_i  (up_data_i),
        .instr_i (up_instr_i),
        .valid_o (skid_valid_s),
        .data_o  (skid_data_s),
        .instr_o (skid_instr_s)
    );

endmodule

// File: tb/tb_if_id_skid_regs.sv
// Scoreboard bench for if_id_skid_regs: driver pushes accepted beats,
// a monitor compares delivered beats and status against a counting model.
`timescale 1ns/100ps
module tb_if_id_skid_regs;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [96:0] data;
        logic [31:0] instr;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        up_valid_i, dn_ready_i, flush_i;
    logic [96:0] up_data_i;
    logic [31:0] up_instr_i;
    logic        up_ready_o, dn_valid_o;
    logic [96:0] dn_data_o;
    logic [31:0] dn_instr_o;
    logic [1:0]  occupancy_o;
    logic [15:0] stall_cnt_o;

    logic        s4_up_ready, s4_dn_valid;
    logic [96:0] s4_dn_data;
    logic [31:0] s4_dn_instr;
    logic [1:0]  s4_occ;
    logic [3:0]  s4_stall;

    beat_t       exp_q[$];
    int          occ_model   = 0;
    int          stall_model = 0;
    int          stall4_model = 0;
    int          errors = 0;
    int          checks = 0;
    bit          comb_probe = 1'b0;

    always #5 clk = ~clk;

    if_id_skid_regs dut (
        .clk(clk), .rst(rst),
        .up_valid_i(up_valid_i), .up_ready_o(up_ready_o),
        .up_data_i(up_data_i), .up_instr_i(up_instr_i),
        .dn_valid_o(dn_valid_o), .dn_ready_i(dn_ready_i),
        .dn_data_o(dn_data_o), .dn_instr_o(dn_instr_o),
        .flush_i(flush_i), .occupancy_o(occupancy_o), .stall_cnt_o(stall_cnt_o)
    );

    if_id_skid_regs #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .up_valid_i(up_valid_i), .up_ready_o(s4_up_ready),
        .up_data_i(up_data_i), .up_instr_i(up_instr_i),
        .dn_valid_o(s4_dn_valid), .dn_ready_i(dn_ready_i),
        .dn_data_o(s4_dn_data), .dn_instr_o(s4_dn_instr),
        .flush_i(flush_i), .occupancy_o(s4_occ), .stall_cnt_o(s4_stall)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus; beats the model says will be accepted are queued.
    task automatic cycle(input bit v, input bit r, input bit f);
        logic [127:0] rnd;
        logic         r0;
        @(negedge clk);
        rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
        up_valid_i = v;
        up_data_i  = rnd[96:0];
        up_instr_i = $urandom();
        dn_ready_i = r;
        flush_i    = f;
        if (f) exp_q.delete();
        else if (v && occ_model < 2) exp_q.push_back('{data: up_data_i, instr: up_instr_i});
        if (comb_probe) begin
            #1 r0 = up_ready_o;
            dn_ready_i = ~r;
            #1 chk("ready_indep_of_dn_ready", 128'(up_ready_o), 128'(r0));
            dn_ready_i = r;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_dn_valid"}, 128'(dn_valid_o), 128'(1'b0));
        chk({tag, "_up_ready"}, 128'(up_ready_o), 128'(1'b1));
        chk({tag, "_dn_data"},  128'(dn_data_o),  128'(0));
        chk({tag, "_dn_instr"}, 128'(dn_instr_o), 128'(NOP));
        chk({tag, "_occ"},      128'(occupancy_o), 128'(0));
        chk({tag, "_stall"},    128'(stall_cnt_o), 128'(0));
    endtask

    // Monitor: compare status with the model and pop beats on downstream fire.
    always begin
        beat_t b;
        int    nxt;
        @(negedge clk);
        #4;
        if (!rst) begin
            chk("occupancy", 128'(occupancy_o), 128'(occ_model));
            chk("up_ready",  128'(up_ready_o),  128'(occ_model < 2));
            chk("dn_valid",  128'(dn_valid_o),  128'(occ_model > 0));
            chk("stall_cnt", 128'(stall_cnt_o), 128'(stall_model));
            chk("stall_cnt4", 128'(s4_stall),   128'(stall4_model));
            if (occ_model == 0) begin
                chk("idle_data",  128'(dn_data_o),  128'(0));
                chk("idle_instr", 128'(dn_instr_o), 128'(NOP));
            end
            if (!flush_i && occ_model > 0 && dn_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 128'(1), 128'(0));
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_instr", 128'(dn_instr_o), 128'(b.instr));
                    chk("beat_data",  128'(dn_data_o),  128'(b.data));
                end
            end
            if (up_valid_i && occ_model == 2) begin
                if (stall_model < 65535) stall_model++;
                if (stall4_model < 15) stall4_model++;
            end
            nxt = occ_model + ((up_valid_i && occ_model < 2) ? 1 : 0)
                            - ((occ_model > 0 && dn_ready_i) ? 1 : 0);
            occ_model = flush_i ? 0 : nxt;
        end
    end

    initial begin
        rst = 1'b1;
        up_valid_i = 1'b0; dn_ready_i = 1'b0; flush_i = 1'b0;
        up_data_i = '0; up_instr_i = '0;
        #1 check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // First beat after reset appears one cycle later.
        @(negedge clk);
        up_valid_i = 1'b1; up_instr_i = 32'h0050_0093; up_data_i = 97'h1_2345;
        dn_ready_i = 1'b1;
        exp_q.push_back('{data: up_data_i, instr: up_instr_i});
        @(negedge clk);
        up_valid_i = 1'b0;
        #1 chk("first_beat_instr", 128'(dn_instr_o), 128'(32'h0050_0093));
        chk("first_beat_occ", 128'(occupancy_o), 128'(1));
        cycle(0, 1, 0);

        // Back-to-back A, B into a stalled downstream, then drain in order.
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        repeat (3) cycle(1, 0, 0);
        cycle(0, 1, 0);
        chk("stall_after_three", 128'(stall_cnt_o), 128'(3));
        cycle(0, 1, 0);
        cycle(0, 0, 0);

        // Flush while in SKID with an incoming beat.
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 1);
        cycle(0, 0, 0);
        chk("flush_occ", 128'(occupancy_o), 128'(0));
        chk("flush_instr", 128'(dn_instr_o), 128'(NOP));
        cycle(1, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 0, 0);

        // Long stall to saturate the 4-bit counter.
        repeat (20) cycle(1, 0, 0);
        cycle(0, 0, 0);
        chk("stall4_saturated", 128'(s4_stall), 128'(4'd15));
        repeat (3) cycle(0, 1, 0);

        // Asynchronous reset pulse between edges while FULL.
        cycle(1, 0, 0);
        @(negedge clk);
        up_valid_i = 1'b0; dn_ready_i = 1'b0; flush_i = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_values("async_rst");
        rst = 1'b0;
        exp_q.delete();
        occ_model = 0; stall_model = 0; stall4_model = 0;

        // Randomized streaming with occasional flushes.
        comb_probe = 1'b1;
        for (int i = 0; i < 220; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0);
        end
        comb_probe = 1'b0;
        repeat (4) cycle(0, 1, 0);
        cycle(0, 0, 0);
        chk("drained", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_id_skid_regs.md
IF_ID_SKID_REGS -- requirements
Module: if_id_skid_regs

Interface
REQ-001 Parameter DATA_W, default 97, SHALL set the sideband payload width (pc+imm, pc+4, jalr target, prediction bit).
REQ-002 Parameter INSTR_W, default 32, SHALL set the instruction field width.
REQ-003 Parameter NOP_INSTR, default 32'h00000013, SHALL set the bubble instruction value.
REQ-004 Parameter CNT_W, default 16, SHALL set the stall counter width.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  SHALL be the reset, asynchronous and active-high.
REQ-007 up_valid_i  in  1  SHALL mark the upstream (IF) beat as valid.
REQ-008 up_ready_o  out  1  SHALL mark that the stage accepts an upstream beat.
REQ-009 up_data_i  in  DATA_W  SHALL carry the upstream sideband payload.
REQ-010 up_instr_i  in  INSTR_W  SHALL carry the upstream instruction.
REQ-011 dn_valid_o  out  1  SHALL mark the downstream (ID) beat as valid.
REQ-012 dn_ready_i  in  1  SHALL mark that downstream accepts the beat.
REQ-013 dn_data_o  out  DATA_W  SHALL carry the downstream payload.
REQ-014 dn_instr_o  out  INSTR_W  SHALL carry the downstream instruction.
REQ-015 flush_i  in  1  SHALL request a synchronous pipeline flush.
REQ-016 occupancy_o  out  2  SHALL report the number of held beats (0, 1 or 2).
REQ-017 stall_cnt_o  out  CNT_W  SHALL report the number of cycles with up_valid_i=1 and up_ready_o=0.

Function
REQ-018 Up fire = up_valid_i & up_ready_o; down fire = dn_valid_o & dn_ready_i.
REQ-019 Storage SHALL be a main slot driving the outputs plus one skid slot; states EMPTY, FULL (main only), SKID (main and skid).
REQ-020 up_ready_o SHALL equal !skid_valid, decoded from registers only, with no combinational path from dn_ready_i.
REQ-021 EMPTY: on up fire, load main and go to FULL; dn_valid_o SHALL rise 1 cycle after up fire.
REQ-022 FULL: up and down fire: main<=up, stay FULL; up fire only: skid<=up, go SKID; down fire only: go EMPTY; neither: hold.
REQ-023 SKID: on down fire, main<=skid, go FULL; otherwise hold all contents.
REQ-024 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated except by flush.
REQ-025 When dn_valid_o=0, dn_data_o SHALL be 0 and dn_instr_o SHALL be NOP_INSTR.
REQ-026 flush_i SHALL take priority over all handshakes: both slots invalidated and next state EMPTY; an up fire in the same cycle SHALL be dropped.
REQ-027 occupancy_o SHALL be 0/1/2 for EMPTY/FULL/SKID, registered.
REQ-028 stall_cnt_o SHALL increment by 1 per qualifying cycle, saturate at 2^CNT_W-1 and be unaffected by flush_i.

Reset
REQ-029 On rst=1, immediately and independent of clk, the block SHALL enter EMPTY with dn_valid_o=0, up_ready_o=1, dn_data_o=0, dn_instr_o=NOP_INSTR, occupancy_o=0 and stall_cnt_o=0.
REQ-030 A reset asserted mid-transfer SHALL discard both slots; the first edge after release SHALL behave as EMPTY.

Structure
REQ-031 The NOP_INSTR default and the state encoding (EMPTY=0, FULL=1, SKID=2) SHALL live in the shared package pl_pkg.
REQ-032 One sub-module, pl_slot, SHALL implement a valid+data+instr register with load and clear, instantiated twice (main, skid).

Verification
REQ-033 Reset release, up_valid_i=1, instr=32'h00500093, dn_ready_i=1 -> next cycle dn_valid_o=1, dn_instr_o=32'h00500093, occupancy_o=1.
REQ-034 dn_ready_i=0 with beats A and B sent back-to-back -> occupancy_o=2 and up_ready_o=0; 3 stall cycles -> stall_cnt_o=3; then dn_ready_i=1 -> A, then B, out in consecutive cycles.
REQ-035 SKID state, flush_i=1 with up_valid_i=1 -> next cycle dn_valid_o=0, dn_instr_o=32'h00000013, dn_data_o=0, occupancy_o=0, incoming beat not seen.
REQ-036 Streaming 100 beats with random dn_ready_i -> output sequence matches input order exactly and up_ready_o never depends combinationally on dn_ready_i.
REQ-037 CNT_W=4, up_valid_i=1 and dn_ready_i=0 for 20 cycles -> stall_cnt_o saturates at 15.
REQ-038 rst pulsed between clock edges while in FULL -> outputs reach reset values before the next edge.
